// File: rtl/krms_req_scheduler.sv
// krms_req_scheduler: shares one krms recompute-scale engine between REQ_NUM
// requesters. Round-robin grant, then configure krms, pulse start, stream
// ceil(K/BUS_NUM) beats from the grantee, wait for the scale (with watchdog)
// and return it to the grantee as a one-cycle pulse.
module krms_req_scheduler #(
  parameter int REQ_NUM        = 4,
  parameter int BUS_NUM        = 8,
  parameter int IDATA_WIDTH    = 8,
  parameter int DATA_NUM_WIDTH = 10,
  parameter int SCALE_WIDTH    = 24,
  parameter int CS_WIDTH       = 3,
  parameter int TIMEOUT        = 1023
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [DATA_NUM_WIDTH-1:0]              cfg_k,
  input  logic [REQ_NUM-1:0]                     req_vld,
  input  logic [REQ_NUM*CS_WIDTH-1:0]            req_cs,
  input  logic [REQ_NUM*BUS_NUM*IDATA_WIDTH-1:0] req_data,
  input  logic [REQ_NUM-1:0]                     req_data_vld,
  output logic [REQ_NUM-1:0]                     req_gnt,
  output logic [REQ_NUM-1:0]                     req_data_rdy,
  output logic [SCALE_WIDTH-1:0]                 resp_scale,
  output logic [REQ_NUM-1:0]                     resp_vld,
  output logic [REQ_NUM-1:0]                     resp_err,
  output logic [CS_WIDTH-1:0]                    krms_cs,
  output logic                                   krms_cs_update,
  output logic                                   krms_start,
  output logic [BUS_NUM*IDATA_WIDTH-1:0]         krms_data,
  output logic                                   krms_data_vld,
  input  logic [SCALE_WIDTH-1:0]                 krms_scale,
  input  logic                                   krms_scale_vld,
  output logic                                   busy
);

  localparam int IDXW = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;
  localparam int DW   = BUS_NUM * IDATA_WIDTH;
  localparam int WDW  = $clog2(TIMEOUT + 1);
  localparam logic [IDXW:0]           REQ_SUM = (IDXW+1)'(REQ_NUM);
  localparam logic [IDXW-1:0]         REQ_LAST = IDXW'(REQ_NUM - 1);
  localparam logic [DATA_NUM_WIDTH:0] BUS_M1  = (DATA_NUM_WIDTH+1)'(BUS_NUM - 1);
  localparam logic [DATA_NUM_WIDTH:0] BUS_EXT = (DATA_NUM_WIDTH+1)'(BUS_NUM);
  localparam logic [WDW-1:0]          WD_LAST = WDW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CFG, S_START, S_STREAM, S_WAIT, S_RESP
  } state_t;

  state_t                    state, state_next;
  logic [IDXW-1:0]           rr_ptr;
  logic [IDXW-1:0]           gnt_idx;
  logic [CS_WIDTH-1:0]       cs_lat;
  logic [DATA_NUM_WIDTH-1:0] beats;
  logic [DATA_NUM_WIDTH-1:0] beat_cnt;
  logic [WDW-1:0]            wd_cnt;
  logic                      err_flag;
  logic [SCALE_WIDTH-1:0]    scale_lat;

  logic [IDXW-1:0]           rot_idx [REQ_NUM];
  logic [REQ_NUM-1:0]        rot_vld;
  logic [IDXW-1:0]           pick_idx;
  logic                      pick_any;
  logic [DATA_NUM_WIDTH:0]   k_ext;
  logic [DATA_NUM_WIDTH-1:0] beats_calc;
  logic                      beat_fire;
  logic                      last_beat;
  logic                      wd_expire;
  logic [REQ_NUM-1:0]        gnt_onehot;

  // Requester visited at offset gi from the round-robin pointer.
  for (genvar gi = 0; gi < REQ_NUM; gi++) begin : g_rot
    logic [IDXW:0] sum;
    assign sum         = {1'b0, rr_ptr} + (IDXW+1)'(gi);
    assign rot_idx[gi] = (sum >= REQ_SUM) ? IDXW'(sum - REQ_SUM) : sum[IDXW-1:0];
    assign rot_vld[gi] = req_vld[rot_idx[gi]];
  end

  // Pick the first requesting slot at or after rr_ptr (lowest offset wins).
  always_comb begin
    pick_any = |rot_vld;
    pick_idx = '0;
    for (int i = REQ_NUM - 1; i >= 0; i--) begin
      if (rot_vld[i]) pick_idx = rot_idx[i];
    end
  end

  assign k_ext      = {1'b0, cfg_k} + BUS_M1;
  assign beats_calc = DATA_NUM_WIDTH'(k_ext / BUS_EXT);
  assign beat_fire  = (state == S_STREAM) && req_data_vld[gnt_idx];
  assign last_beat  = beat_fire && (DATA_NUM_WIDTH'(beat_cnt + 1'b1) == beats);
  assign wd_expire  = (state == S_WAIT) && (wd_cnt == WD_LAST);
  assign gnt_onehot = REQ_NUM'(1) << gnt_idx;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // Next-state decode; a zero K skips the krms run and reports an error.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (pick_any) state_next = S_CFG;
      S_CFG:    state_next = (beats == '0) ? S_RESP : S_START;
      S_START:  state_next = S_STREAM;
      S_STREAM: if (last_beat) state_next = S_WAIT;
      S_WAIT:   if (krms_scale_vld || wd_expire) state_next = S_RESP;
      S_RESP:   state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Transaction context: grantee, cs, beat/watchdog counters, result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr    <= '0;
      gnt_idx   <= '0;
      cs_lat    <= '0;
      beats     <= '0;
      beat_cnt  <= '0;
      wd_cnt    <= '0;
      err_flag  <= 1'b0;
      scale_lat <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pick_any) begin
            gnt_idx  <= pick_idx;
            cs_lat   <= req_cs[pick_idx*CS_WIDTH +: CS_WIDTH];
            beats    <= beats_calc;
            beat_cnt <= '0;
            wd_cnt   <= '0;
            err_flag <= 1'b0;
          end
        end
        S_CFG: begin
          if (beats == '0) err_flag <= 1'b1;
        end
        S_STREAM: begin
          if (beat_fire) beat_cnt <= beat_cnt + 1'b1;
        end
        S_WAIT: begin
          wd_cnt <= wd_cnt + 1'b1;
          // A scale arriving in the expiry cycle still counts as success.
          if (krms_scale_vld) begin
            scale_lat <= krms_scale;
            err_flag  <= 1'b0;
          end else if (wd_expire) begin
            err_flag <= 1'b1;
          end
        end
        S_RESP: begin
          rr_ptr   <= (gnt_idx == REQ_LAST) ? '0 : gnt_idx + 1'b1;
          beat_cnt <= '0;
          wd_cnt   <= '0;
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from state and latched context; data path forwards live.
  always_comb begin
    busy           = (state != S_IDLE);
    req_gnt        = busy ? gnt_onehot : '0;
    req_data_rdy   = (state == S_STREAM) ? gnt_onehot : '0;
    krms_cs        = (state == S_CFG) ? cs_lat : '0;
    krms_cs_update = (state == S_CFG);
    krms_start     = (state == S_START);
    krms_data_vld  = beat_fire;
    krms_data      = beat_fire ? req_data[gnt_idx*DW +: DW] : '0;
    resp_vld       = (state == S_RESP && !err_flag) ? gnt_onehot : '0;
    resp_err       = (state == S_RESP && err_flag) ? gnt_onehot : '0;
    resp_scale     = (state == S_RESP && !err_flag) ? scale_lat : '0;
  end

endmodule

// File: tb/tb_krms_req_scheduler.sv
// Testbench for krms_req_scheduler: transaction-level reference model plus
// directed scenarios (single, round robin, bubbles, K=0, timeout, reset).
module tb_krms_req_scheduler;
  localparam int RN = 4, BN = 8, IW = 8, KW = 10, SW = 24, CW = 3, TO = 15;
  localparam int DW = BN * IW;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [KW-1:0]     cfg_k = '0;
  logic [RN-1:0]     req_vld = '0;
  logic [RN*CW-1:0]  req_cs = '0;
  logic [RN*DW-1:0]  req_data = '0;
  logic [RN-1:0]     req_data_vld = '0;
  logic [SW-1:0]     krms_scale = '0;
  logic              krms_scale_vld = 1'b0;
  logic [RN-1:0]     req_gnt, req_data_rdy, resp_vld, resp_err;
  logic [SW-1:0]     resp_scale;
  logic [CW-1:0]     krms_cs;
  logic              krms_cs_update, krms_start, krms_data_vld, busy;
  logic [DW-1:0]     krms_data;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  krms_req_scheduler #(
    .REQ_NUM(RN), .BUS_NUM(BN), .IDATA_WIDTH(IW), .DATA_NUM_WIDTH(KW),
    .SCALE_WIDTH(SW), .CS_WIDTH(CW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg_k(cfg_k), .req_vld(req_vld), .req_cs(req_cs),
    .req_data(req_data), .req_data_vld(req_data_vld), .req_gnt(req_gnt),
    .req_data_rdy(req_data_rdy), .resp_scale(resp_scale), .resp_vld(resp_vld),
    .resp_err(resp_err), .krms_cs(krms_cs), .krms_cs_update(krms_cs_update),
    .krms_start(krms_start), .krms_data(krms_data), .krms_data_vld(krms_data_vld),
    .krms_scale(krms_scale), .krms_scale_vld(krms_scale_vld), .busy(busy)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t got=%h want=%h", nm, $time, act, exp);
    end
  endtask

  // Reference model: owner (-1 = none), cycles since grant, beats left,
  // cycles spent waiting, pending response.
  int             m_owner = -1;
  int             m_age = 0, m_left = 0, m_waitc = 0, m_rr = 0;
  bit             m_resp = 0, m_err = 0, m_kzero = 0;
  logic [CW-1:0]  m_cs = '0;
  logic [SW-1:0]  m_scale = '0;

  function automatic bit m_stream();
    return m_owner >= 0 && !m_resp && m_age >= 3 && m_left > 0;
  endfunction

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_owner = -1; m_rr = 0; m_resp = 0; m_err = 0; m_age = 0; m_left = 0; m_waitc = 0;
    end else if (m_owner < 0) begin
      for (int i = RN - 1; i >= 0; i--)
        if (req_vld[(m_rr + i) % RN]) m_owner = (m_rr + i) % RN;
      if (m_owner >= 0) begin
        m_age = 1; m_left = (int'(cfg_k) + BN - 1) / BN; m_kzero = (cfg_k == 0);
        m_cs = req_cs[m_owner*CW +: CW]; m_waitc = 0; m_resp = 0; m_err = 0;
      end
    end else if (m_resp) begin
      m_rr = (m_owner + 1) % RN; m_owner = -1; m_resp = 0;
    end else if (m_age == 1) begin
      m_age = 2;
      if (m_kzero) begin m_resp = 1; m_err = 1; end
    end else if (m_age == 2) begin
      m_age = 3;
    end else if (m_left > 0) begin
      if (req_data_vld[m_owner]) m_left--;
    end else begin
      m_waitc++;
      if (krms_scale_vld) begin m_resp = 1; m_err = 0; m_scale = krms_scale; end
      else if (m_waitc == TO) begin m_resp = 1; m_err = 1; end
    end
  end

  // Per-cycle comparison of every output against the model.
  initial forever begin
    @(negedge clk);
    #2;
    begin
      bit b, cfg, st, strm, fire;
      int o;
      logic [RN-1:0] oh;
      b    = m_owner >= 0;
      o    = b ? m_owner : 0;
      oh   = b ? (RN'(1) << o) : '0;
      cfg  = b && !m_resp && m_age == 1;
      st   = b && !m_resp && m_age == 2;
      strm = m_stream();
      fire = strm && req_data_vld[o];
      chk("busy", busy, b);
      chk("gnt", req_gnt, oh);
      chk("rdy", req_data_rdy, strm ? oh : '0);
      chk("cs_update", krms_cs_update, cfg);
      chk("cs", krms_cs, cfg ? m_cs : '0);
      chk("start", krms_start, st);
      chk("data_vld", krms_data_vld, fire);
      chk("data", krms_data, fire ? req_data[o*DW +: DW] : '0);
      chk("resp_vld", resp_vld, (m_resp && !m_err) ? oh : '0);
      chk("resp_err", resp_err, (m_resp && m_err) ? oh : '0);
      chk("resp_scale", resp_scale, (m_resp && !m_err) ? m_scale : '0);
      if (resp_vld != 0 || resp_err != 0)
        $display("txn t=%0t vld=%b err=%b scale=%h", $time, resp_vld, resp_err, resp_scale);
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic rand_data();
    for (int i = 0; i < RN*DW/32; i++) req_data[i*32 +: 32] = $urandom;
  endtask

  initial begin
    int n;
    logic [RN-1:0] order [5];
    logic [RN-1:0] prev;
    int cnt;
    bit pat [5];
    pat = '{1, 0, 0, 1, 1};

    // Reset state
    repeat (2) step();
    #3;
    chk("rst_busy", busy, 0);
    chk("rst_gnt", req_gnt, 0);
    chk("rst_start", krms_start, 0);
    step(); rst_n = 1'b1;

    // T1 single request, K=16 -> 2 beats
    step(); req_vld = 4'b0001; cfg_k = 10'd16; req_data_vld = 4'b1111;
    req_cs = 12'h005; rand_data();
    step(); req_vld = '0; #3;
    chk("t1_cfg", {krms_cs_update, req_gnt, krms_cs}, {1'b1, 4'b0001, 3'd5});
    step(); #3; chk("t1_start", krms_start, 1);
    step(); #3; chk("t1_beat1", krms_data_vld, 1);
    step(); #3; chk("t1_beat2", krms_data, req_data[DW-1:0]);
    step(); krms_scale_vld = 1'b1; krms_scale = 24'h123456; #3;
    chk("t1_wait", {busy, req_data_rdy}, {1'b1, 4'b0000});
    step(); krms_scale_vld = 1'b0; #3;
    chk("t1_resp", {resp_vld, resp_scale}, {4'b0001, 24'h123456});
    step(); #3; chk("t1_idle", busy, 0);

    // T4 K=0 on requester 2 (rr_ptr now 1)
    step(); req_vld = 4'b0100; cfg_k = 10'd0;
    step(); req_vld = '0; #3; chk("t4_gnt", req_gnt, 4'b0100);
    step(); #3; chk("t4_err", {resp_err, krms_start}, {4'b0100, 1'b0});
    step(); req_vld = 4'b1111; cfg_k = 10'd8;
    step(); req_vld = '0; #3; chk("t4_next_gnt", req_gnt, 4'b1000);
    krms_scale_vld = 1'b1;
    for (n = 0; n < 50 && busy; n++) step();
    chk("t4_done", busy, 0);
    krms_scale_vld = 1'b0;

    // T3 bubbles, K=24 -> 3 beats (rr_ptr now 0)
    step(); req_vld = 4'b0001; cfg_k = 10'd24; req_data_vld = '0;
    step(); req_vld = '0; #3; chk("t3_gnt", req_gnt, 4'b0001);
    step();
    for (int p = 0; p < 5; p++) begin
      step(); req_data_vld = pat[p] ? 4'b1111 : 4'b0000; rand_data(); #3;
      chk("t3_beat", krms_data_vld, pat[p]);
    end
    step(); req_data_vld = '0; #3;
    chk("t3_wait", {busy, req_data_rdy}, {1'b1, 4'b0000});
    krms_scale_vld = 1'b1; krms_scale = 24'hABCDEF;
    step(); step(); krms_scale_vld = 1'b0;

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      step();
      if (m_owner < 0 && $urandom_range(3) == 0) begin
        case ($urandom_range(7))
          0: cfg_k = 10'd0;   1: cfg_k = 10'd1;  2: cfg_k = 10'd7;  3: cfg_k = 10'd8;
          4: cfg_k = 10'd9;   5: cfg_k = 10'd16; 6: cfg_k = 10'd24;
          default: cfg_k = KW'($urandom_range(80));
        endcase
      end
      req_vld        = ($urandom_range(2) == 0) ? RN'($urandom) : '0;
      req_cs         = (RN*CW)'($urandom);
      req_data_vld   = RN'($urandom) | RN'($urandom);
      rand_data();
      krms_scale_vld = ($urandom_range(7) == 0);
      krms_scale     = SW'($urandom);
    end

    // T6 reset while streaming
    req_vld = 4'b1111; cfg_k = 10'd40; krms_scale_vld = 1'b0; req_data_vld = 4'b0101;
    for (n = 0; n < 200 && !m_stream(); n++) step();
    chk("t6_in_stream", m_stream(), 1);
    rst_n = 1'b0; #3;
    chk("t6_rst", {busy, req_gnt, req_data_rdy, krms_data_vld}, 0);
    step(); step();
    rst_n = 1'b1; req_vld = 4'b1111; cfg_k = 10'd8; req_data_vld = 4'b1111;

    // T5 timeout: krms never answers
    step(); req_vld = '0; #3; chk("t6_gnt_rr0", req_gnt, 4'b0001);
    for (n = 1; n <= 100; n++) begin
      step(); #3;
      if (resp_err != 0) break;
    end
    chk("t5_lat", n, 18);
    chk("t5_err", resp_err, 4'b0001);
    step(); krms_scale_vld = 1'b1; krms_scale = 24'h777777;
    step(); krms_scale_vld = 1'b0; #3;
    chk("t5_stray", {resp_vld, busy}, 0);

    // T2 round-robin with all requesting (rr_ptr now 1)
    req_vld = 4'b1111; cfg_k = 10'd8; req_data_vld = 4'b1111; krms_scale_vld = 1'b1;
    for (int i = 0; i < 5; i++) order[i] = '0;
    prev = '0; cnt = 0;
    for (int c = 0; c < 100 && cnt < 5; c++) begin
      step(); #3;
      if (req_gnt != 0 && req_gnt != prev) begin order[cnt] = req_gnt; cnt++; end
      prev = req_gnt;
    end
    req_vld = '0;
    chk("t2_g0", order[0], 4'b0010);
    chk("t2_g1", order[1], 4'b0100);
    chk("t2_g2", order[2], 4'b1000);
    chk("t2_g3", order[3], 4'b0001);
    chk("t2_g4", order[4], 4'b0010);
    repeat (10) step();
    krms_scale_vld = 1'b0;
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
